// File: rtl/multdiv_iter_unit.sv
// multdiv_iter_unit
// Iterative signed multiply/divide unit for the execute stage. One radix-2
// step per cycle over operand magnitudes, then a fix-up cycle that applies
// signs and flags exceptions. Fixed latency regardless of operand values.
//
// Ports
//   clock          : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   ctrl_MULT      : one-cycle pulse, start A*B (wins if ctrl_DIV also high)
//   ctrl_DIV       : one-cycle pulse, start A/B
//   data_operandA  : multiplicand / dividend, sampled on accept
//   data_operandB  : multiplier / divisor, sampled on accept
//   data_result    : low product word or quotient, held until next FIX
//   data_exception : overflow / divide-by-zero, qualified by data_resultRDY
//   data_resultRDY : one-cycle result-valid pulse
//   busy           : high from accept until the RDY cycle
//   data_aux       : (MULTDIV_REM_EN only) high product word / remainder
//
// Build option: define MULTDIV_REM_EN to add the data_aux output.

module multdiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULTDIV_REM_EN
    ,
    output logic [WIDTH-1:0] data_aux
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic               min_neg1;
    logic [WIDTH-1:0]   opnd_mag;
    logic [2*WIDTH-1:0] acc;
    logic               exc_q;

    logic               accept;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exc;
    logic [WIDTH-1:0]   fix_aux;

    assign accept = ctrl_MULT | ctrl_DIV;

    // Magnitude of MIN wraps to itself, which is the correct unsigned value.
    assign mag_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply: acc = {partial high, multiplier}; add to the high half when
    // the multiplier LSB is set, then shift right with the carry.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_mag};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {remainder, quotient/dividend}; restoring step.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd_mag};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign fix-up and exception evaluation for the FIX cycle.
    always_comb begin
        prod_s     = (sign_a ^ sign_b) ? -acc : acc;
        quo_s      = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s      = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_result = '0;
        fix_exc    = 1'b0;
        fix_aux    = '0;
        if (!op_div) begin
            fix_result = prod_s[WIDTH-1:0];
            fix_exc    = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
            fix_aux    = prod_s[2*WIDTH-1:WIDTH];
        end else if (b_zero) begin
            fix_result = '0;
            fix_exc    = 1'b1;
            fix_aux    = '0;
        end else begin
            fix_result = quo_s;
            fix_exc    = min_neg1;
            fix_aux    = rem_s;
        end
    end

    // Control FSM and datapath registers. A new command is accepted in any
    // state and silently abandons whatever was in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_div         <= 1'b0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            b_zero         <= 1'b0;
            min_neg1       <= 1'b0;
            opnd_mag       <= '0;
            acc            <= '0;
            exc_q          <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_REM_EN
            data_aux       <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (accept) begin
                op_div   <= ~ctrl_MULT;
                sign_a   <= data_operandA[WIDTH-1];
                sign_b   <= data_operandB[WIDTH-1];
                b_zero   <= (data_operandB == '0);
                min_neg1 <= (data_operandA == MIN_VAL) && (data_operandB == '1);
                opnd_mag <= ctrl_MULT ? mag_a_in : mag_b_in;
                acc      <= ctrl_MULT ? {{WIDTH{1'b0}}, mag_b_in} : {{WIDTH{1'b0}}, mag_a_in};
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= RUN;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        acc <= op_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        data_result    <= fix_result;
                        exc_q          <= fix_exc;
`ifdef MULTDIV_REM_EN
                        data_aux       <= fix_aux;
`else
                        // fix_aux is only consumed when data_aux is present
`endif
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign data_exception = exc_q & data_resultRDY;

endmodule
